// File: rtl/timer_request_sequencer_if.sv
// Request, counter and status signals of timer_request_sequencer.
// The slave modport is the sequencer's side of the bus.
interface timer_request_sequencer_if #(
  parameter int DEPTH = 4
);
  logic                   req_valid;
  logic                   req_ready;
  logic [1:0]             req_mult;
  logic [3:0]             req_reps;
  logic                   tr;
  logic [1:0]             multiplier;
  logic                   cf;
  logic                   busy;
  logic                   done;
  logic [1:0]             done_mult;
  logic [$clog2(DEPTH):0] fifo_level;
  logic                   timeout_err;

  modport slave (
    input  req_valid, req_mult, req_reps, cf,
    output req_ready, tr, multiplier, busy, done, done_mult, fifo_level, timeout_err
  );

  modport master (
    output req_valid, req_mult, req_reps, cf,
    input  req_ready, tr, multiplier, busy, done, done_mult, fifo_level, timeout_err
  );
endinterface

// File: rtl/timer_request_sequencer.sv
// Queues timer requests and replays each one as tr pulses into the cf/tr run counter.
// Optional WAIT_END watchdog: define TIMER_REQUEST_SEQUENCER_WATCHDOG_EN.
module timer_request_sequencer #(
  parameter int DEPTH  = 4,
  parameter int TVALUE = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  timer_request_sequencer_if.slave      bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TVALUE < 1) begin : g_bad_param
    $error("timer_request_sequencer: DEPTH must be a power of 2 >= 2 and TVALUE >= 1");
  end

  typedef struct packed {
    logic [1:0] mult;
    logic [3:0] reps;
  } req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, ARM, WAIT_END} state_t;

  req_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level;
  logic          full, empty, push, pop;

  state_t        state, state_nxt;
  logic [1:0]    mult_q;
  logic [3:0]    remaining;
  logic          done_q;
  logic [1:0]    done_mult_q;
  logic          run_done, last_done, wd_fire;

  assign full  = (level == FULL_LVL);
  assign empty = (level == '0);
  // Acceptance depends on the current level only, so a same-cycle pop never frees a full FIFO.
  assign push  = bus.req_valid && !full;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{mult: bus.req_mult, reps: bus.req_reps};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

`ifdef TIMER_REQUEST_SEQUENCER_WATCHDOG_EN
  localparam logic [31:0] WD_LIMIT = 32'(8 * TVALUE);
  logic [31:0] wd_cnt;
  logic        timeout_q;
  // wd_cnt holds the number of WAIT_END cycles already spent before the current one.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == ARM && !bus.cf)  wd_cnt <= '0;
      else if (state == WAIT_END)   wd_cnt <= wd_cnt + 32'd1;
      if (wd_fire) timeout_q <= 1'b1;
    end
  end
  assign bus.timeout_err = timeout_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    run_done  = 1'b0;
    wd_fire   = 1'b0;
    case (state)
      IDLE:     if (!empty && bus.cf) begin
                  pop       = 1'b1;
                  state_nxt = ISSUE;
                end
      ISSUE:    state_nxt = ARM;
      // cf already high right after the tr edge means a zero-length run.
      ARM:      if (bus.cf) run_done = 1'b1;
                else        state_nxt = WAIT_END;
      WAIT_END: begin
                  if (bus.cf) run_done = 1'b1;
`ifdef TIMER_REQUEST_SEQUENCER_WATCHDOG_EN
                  else if (wd_cnt >= WD_LIMIT) wd_fire = 1'b1;
`endif
                end
      default:  state_nxt = IDLE;
    endcase
    if (run_done) state_nxt = (remaining == '0) ? IDLE : ISSUE;
    if (wd_fire)  state_nxt = IDLE;
  end

  assign last_done = (run_done && remaining == '0) || wd_fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      mult_q      <= '0;
      remaining   <= '0;
      done_q      <= 1'b0;
      done_mult_q <= '0;
    end else begin
      if (pop) begin
        mult_q    <= mem[rd_ptr].mult;
        remaining <= mem[rd_ptr].reps;
      end else if (wd_fire) begin
        remaining <= '0;
      end else if (run_done && remaining != '0) begin
        remaining <= remaining - 4'd1;
      end
      done_q <= last_done;
      if (last_done) done_mult_q <= mult_q;
    end
  end

  assign bus.req_ready  = !full;
  assign bus.tr         = (state == ISSUE);
  assign bus.multiplier = mult_q;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = done_q;
  assign bus.done_mult  = done_mult_q;
  assign bus.fifo_level = level;
endmodule

// File: tb/tb_timer_request_sequencer.sv
// Bench for timer_request_sequencer: behavioural run counter, request scoreboard,
// directed timing scenarios and a randomized request stream.
module tb_timer_request_sequencer;
  localparam int DEPTH = 4;
  localparam int TV    = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  timer_request_sequencer_if #(.DEPTH(DEPTH)) bus ();
  timer_request_sequencer #(.DEPTH(DEPTH), .TVALUE(TV)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Downstream counter: a run lasts factor*tv cycles, cf low for all but the last.
  int   tv = 3;
  logic cf_hold = 1'b0;
  int   cnt = 0;
  always @(posedge clk) begin
    if (reset) cnt <= 0;
    else if (bus.tr && cnt == 0) cnt <= (1 << bus.multiplier) * tv - 1;
    else if (cnt > 0) cnt <= cnt - 1;
  end
  assign bus.cf = (cnt == 0) && !cf_hold;

  // Scoreboard: requests complete in acceptance order with reps+1 triggers each.
  typedef struct { logic [1:0] mult; logic [3:0] reps; } exp_t;
  exp_t exp_q[$];
  exp_t pend;
  logic pend_push = 1'b0;
  int   trs = 0, n_acc = 0, n_start = 0;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      pend_push = 1'b0;
      trs = 0; n_acc = 0; n_start = 0;
    end else begin
      if (pend_push) begin
        exp_q.push_back(pend);
        n_acc++;
      end
      if (bus.tr) begin
        if (trs == 0) n_start++;
        trs++;
        if (exp_q.size() == 0) chk("sb_tr_unexpected", 1, 0);
        else chk("sb_tr_mult", bus.multiplier, exp_q[0].mult);
      end
      chk("sb_level", bus.fifo_level, n_acc - n_start);
      chk("sb_ready", bus.req_ready, (n_acc - n_start) < DEPTH);
      if (bus.done) begin
        if (exp_q.size() == 0) chk("sb_done_unexpected", 1, 0);
        else begin
          chk("sb_done_mult", bus.done_mult, exp_q[0].mult);
          if (!bus.timeout_err) chk("sb_tr_count", trs, exp_q[0].reps + 1);
          void'(exp_q.pop_front());
        end
        trs = 0;
      end
`ifndef TIMER_REQUEST_SEQUENCER_WATCHDOG_EN
      chk("sb_no_timeout", bus.timeout_err, 0);
`endif
      pend_push = bus.req_valid && bus.req_ready;
      pend.mult = bus.req_mult;
      pend.reps = bus.req_reps;
    end
  end

  logic [63:0] tr_t, cf_t, done_t, busy_t;
  logic [1:0]  dm_t [64];

  task automatic push_and_trace(input logic [1:0] m, input logic [3:0] r, input int n);
    tr_t = '0; cf_t = '0; done_t = '0; busy_t = '0;
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_mult = m; bus.req_reps = r;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tr_t[i] = bus.tr; cf_t[i] = bus.cf; done_t[i] = bus.done;
      busy_t[i] = bus.busy; dm_t[i] = bus.done_mult;
      @(posedge clk); #1;
      if (i == 0) bus.req_valid = 1'b0;
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int k;
    k = 0;
    while ((bus.busy || bus.fifo_level != 0 || bus.done) && k < max) begin
      @(posedge clk); #1; k++;
    end
    chk(tag, k < max, 1);
  endtask

  logic [1:0] q2 [5];
  logic [1:0] got2 [4];
  int nd, k;

  initial begin
    bus.req_valid = 1'b0; bus.req_mult = '0; bus.req_reps = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_tr", bus.tr, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_level", bus.fifo_level, 0);
    chk("rst_mult", bus.multiplier, 0);
    chk("rst_done_mult", bus.done_mult, 0);
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_timeout", bus.timeout_err, 0);

    // Single request, 2x, tvalue 7.
    tv = 7;
    push_and_trace(2'b01, 4'd0, 20);
    chk("t1_tr_c2", tr_t[2], 1);
    chk("t1_tr_once", $countones(tr_t[19:0]), 1);
    chk("t1_cf_c2", cf_t[2], 1);
    chk("t1_cf_c3", cf_t[3], 0);
    chk("t1_cf_c15", cf_t[15], 0);
    chk("t1_cf_c16", cf_t[16], 1);
    chk("t1_cf_low", 20 - $countones(cf_t[19:0]), 13);
    chk("t1_done_c17", done_t[17], 1);
    chk("t1_done_once", $countones(done_t[19:0]), 1);
    chk("t1_done_mult", dm_t[17], 2'b01);
    chk("t1_busy_c17", busy_t[17], 0);
    chk("t1_busy_c19", busy_t[19], 0);

    // FIFO fill with counter stalled, then drain in order.
    tv = 2; cf_hold = 1'b1;
    q2[0] = 2'd3; q2[1] = 2'd1; q2[2] = 2'd2; q2[3] = 2'd0; q2[4] = 2'd3;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus.req_valid = 1'b1; bus.req_mult = q2[i]; bus.req_reps = 4'd0;
      @(negedge clk);
      chk("t2_ready", bus.req_ready, i < 4);
      chk("t2_level", bus.fifo_level, i);
    end
    @(posedge clk); #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("t2_full_level", bus.fifo_level, 4);
    chk("t2_stalled_busy", bus.busy, 0);
    @(posedge clk); #1 cf_hold = 1'b0;
    nd = 0; k = 0;
    while (nd < 4 && k < 400) begin
      @(negedge clk);
      if (bus.done) begin got2[nd] = bus.done_mult; nd++; end
      k++;
    end
    chk("t2_ndone", nd, 4);
    for (int i = 0; i < 4; i++) chk("t2_order", (i < nd) ? got2[i] : 2'bxx, q2[i]);
    wait_idle("t2_idle", 50);

    // Three runs of 1x, tvalue 3.
    tv = 3;
    push_and_trace(2'b00, 4'd2, 20);
    chk("t3_tr_pattern", tr_t[19:0], 20'h00444);
    chk("t3_cf_low", 20 - $countones(cf_t[19:0]), 6);
    chk("t3_done_c14", done_t[14], 1);
    chk("t3_done_once", $countones(done_t[19:0]), 1);
    chk("t3_busy_c15", busy_t[15], 0);

    // Zero-length run.
    tv = 1;
    push_and_trace(2'b00, 4'd0, 8);
    chk("t4_tr_c2", tr_t[2], 1);
    chk("t4_cf_never_low", $countones(cf_t[7:0]), 8);
    chk("t4_done_c4", done_t[4], 1);
    chk("t4_done_once", $countones(done_t[7:0]), 1);
    chk("t4_busy_c5", busy_t[5], 0);

    // Reset while waiting for the end of a run with two queued requests.
    tv = 7;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus.req_valid = 1'b1; bus.req_mult = 2'(i + 1); bus.req_reps = 4'd1;
    end
    @(posedge clk); #1 bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t5_pre_level", bus.fifo_level, 2);
    chk("t5_pre_busy", bus.busy, 1);
    chk("t5_pre_cf", bus.cf, 0);
    pulse_reset();
    @(negedge clk);
    chk("t5_busy", bus.busy, 0);
    chk("t5_level", bus.fifo_level, 0);
    chk("t5_tr", bus.tr, 0);
    nd = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.done || bus.tr) nd++;
    end
    chk("t5_no_activity", nd, 0);

    // Randomized request stream against the scoreboard.
    tv = $urandom_range(1, 3);
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      bus.req_valid = ($urandom_range(0, 3) == 0);
      bus.req_mult  = 2'($urandom_range(0, 3));
      bus.req_reps  = 4'($urandom_range(0, 2));
    end
    bus.req_valid = 1'b0;
    wait_idle("rnd_drain", 3000);
    @(negedge clk);
    chk("rnd_sb_empty", exp_q.size(), 0);

`ifdef TIMER_REQUEST_SEQUENCER_WATCHDOG_EN
    // Counter stuck low after the first trigger.
    tv = 2;
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_mult = 2'b00; bus.req_reps = 4'd3;
    @(posedge clk); #1 bus.req_valid = 1'b0;
    k = 0;
    while (!bus.tr && k < 20) begin @(posedge clk); #1; k++; end
    chk("wd_tr_seen", bus.tr, 1);
    cf_hold = 1'b1;
    nd = 0; k = 0;
    while (nd == 0 && k < 8 * TV + 20) begin
      @(negedge clk);
      if (bus.done) nd++;
      else chk("wd_no_early_err", bus.timeout_err, 0);
      k++;
    end
    chk("wd_done", nd, 1);
    chk("wd_err", bus.timeout_err, 1);
    chk("wd_cycles", k, 8 * TV + 3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("wd_sticky", bus.timeout_err, 1);
      chk("wd_idle", bus.busy, 0);
    end
    cf_hold = 1'b0;
    pulse_reset();
    @(negedge clk);
    chk("wd_cleared", bus.timeout_err, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/timer_request_sequencer.md
Name: timer_request_sequencer

Overview:
- Upstream feeder for the parametrized cf/tr run counter.
- Buffers timer requests (multiplier plus repeat count) in a small FIFO.
- Issues each request to the counter as single-cycle tr pulses with a stable multiplier, and tracks cf to detect run completion.
- Reports per-request completion and handles back-to-back repeats without software intervention.

Parameters:
- DEPTH, 4: request FIFO entries; power of 2, at least 2.
- TVALUE, 4: must equal the downstream counter's tvalue; used only by the optional watchdog; at least 1.

Ports:
- clk  in  1  clock, positive edge.
- reset  in  1  synchronous, active-high. Also drives the downstream counter's reset.
- req_valid  in  1  request offered.
- req_ready  out  1  request can be accepted; equals !fifo_full.
- req_mult  in  2  multiplier code (00=1x, 01=2x, 10=4x, 11=8x).
- req_reps  in  4  runs minus one (0 gives 1 run, 15 gives 16 runs).
- tr  out  1  trigger to counter; high only in ISSUE state.
- multiplier  out  2  multiplier to counter; held stable from ISSUE until completion of the last run.
- cf  in  1  counter idle flag (1 = idle, 0 = running).
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse, registered, after the last run of a request completes.
- done_mult  out  2  multiplier of the request that raised done; valid while done=1.
- fifo_level  out  $clog2(DEPTH)+1  entries currently queued.
- timeout_err  out  1  sticky watchdog error; present only with the optional feature, otherwise tied 0.

Behaviour:
- Reset values: state IDLE, FIFO empty (fifo_level=0), tr=0, multiplier=00, done=0, done_mult=00, busy=0, timeout_err=0, remaining-run counter=0.
- Push: occurs when req_valid && req_ready at a clock edge. req_ready is computed from the current level only. When full, nothing is accepted, even if a pop happens in the same cycle.
- Simultaneous push and pop when not full: level is unchanged and both the data write and the pointer advance happen.
- Pointers wrap modulo DEPTH.
- FSM states IDLE, ISSUE, ARM, WAIT_END:
  - IDLE: if FIFO non-empty && cf==1, pop the head, latch multiplier and remaining=req_reps, go to ISSUE. If cf==0 (counter externally busy), stay in IDLE.
  - ISSUE: tr=1 for exactly this one cycle, then go to ARM.
  - ARM: samples cf in the cycle after the tr edge. If cf==0, go to WAIT_END. If cf==1, the run counts as complete (zero-length run, e.g. TVALUE=1 with 1x).
  - WAIT_END: hold until cf==1; the run is complete in that cycle.
  - On run complete with remaining>0: decrement remaining, go to ISSUE.
  - On run complete with remaining==0: done=1 in the next cycle, go to IDLE.
- Latency: request accepted at the end of cycle 0, IDLE sees it in cycle 1, tr=1 in cycle 2, cf low from cycle 3.
- Repeat gap: a completion detected in cycle k gives ISSUE (tr) in cycle k+1, so each repeat costs 2 idle cycles between runs.
- Completion-to-next-request: done in cycle k+1 coincides with IDLE. The next request's tr arrives in cycle k+2 at the earliest.
- tr never asserts while state≠ISSUE, and ISSUE is never entered unless cf was 1 (IDLE) or the previous run just completed.
- multiplier changes only on the IDLE→ISSUE transition.
- reset mid-run: FSM returns to IDLE, FIFO is flushed, pending requests are discarded, and no done pulse is produced.

Optional Feature:
- Macro: TIMER_REQUEST_SEQUENCER_WATCHDOG_EN.
- Defined:
  - A 32-bit watchdog counts cycles in WAIT_END; it clears on entering WAIT_END.
  - If the count exceeds 8*TVALUE, set timeout_err (sticky until reset).
  - Force the current request complete with done pulsed.
  - Discard its remaining repeats and return to IDLE.
- Undefined: no watchdog logic; timeout_err is a constant 0 and WAIT_END waits indefinitely.

Test Plan:
- Reset, then TVALUE=7, one request mult=01 reps=0 with the real counter attached -> tr=1 in cycle 2 only, cf low cycles 3..15 (13 cycles), done=1 in cycle 17 with done_mult=01, busy 0 afterwards.
- Push 5 requests back-to-back with DEPTH=4 and the FSM stalled (cf forced 0) -> req_ready falls after the 4th, fifo_level=4, 5th not accepted; release cf -> requests popped in order.
- mult=00 reps=2, TVALUE=3 -> three tr pulses, each separated by a 2-cycle cf low window plus 2 gap cycles; single done after the third run.
- TVALUE=1, mult=00 -> ARM sees cf=1, run treated as complete, done pulses, no hang.
- Assert reset during WAIT_END with 2 queued entries -> next cycle state IDLE, fifo_level=0, tr=0, no done.
- Watchdog enabled with cf held 0 after tr -> timeout_err=1 after 8*TVALUE+1 WAIT_END cycles, done pulses, and the error stays high until reset.
